// File: rtl/shadow_wbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shadow_wbuf                                                   |
// | Purpose  : Write buffer that captures CPU writes into shadowed video     |
// |            regions (text, hires, super-hires) and drains them to slow    |
// |            RAM, one entry per 1 MHz drain strobe, in push order.         |
// | Ports    : clk_sys            - system clock (only clock)               |
// |            reset              - synchronous, active-high reset          |
// |            fast_clk           - CPU bus strobe; bank/addr/dout/we valid |
// |            slow_clk           - drain strobe                            |
// |            bank, addr, dout, we - CPU bus                               |
// |            shadow             - inhibit bits (1 = region not shadowed)  |
// |            sr_addr, sr_din, sr_we - slow RAM write port                 |
// |            stall              - FIFO full, CPU must hold off            |
// |            fifo_count         - occupancy 0..DEPTH                      |
// |            overflow           - sticky: a qualifying write was dropped  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module shadow_wbuf #(
   parameter int DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        fast_clk,
   input  logic        slow_clk,
   input  logic [7:0]  bank,
   input  logic [15:0] addr,
   input  logic [7:0]  dout,
   input  logic        we,
   input  logic [7:0]  shadow,
   output logic [16:0] sr_addr,
   output logic [7:0]  sr_din,
   output logic        sr_we,
   output logic        stall,
   output logic [4:0]  fifo_count,
   output logic        overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Entry layout: {bank[0], addr[15:0], data[7:0]}
   logic [24:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   logic in_text1, in_text2, in_hires1, in_hires2, in_shr;
   logic region_ok, qualify;
   logic do_pop, do_push, full;
   logic [4:0] count_next;

   // Region decode; overlapping regions qualify if any enabling bit permits.
   always_comb begin
      in_text1  = (addr >= 16'h0400) && (addr <= 16'h07FF);
      in_text2  = (addr >= 16'h0800) && (addr <= 16'h0BFF);
      in_hires1 = (addr >= 16'h2000) && (addr <= 16'h3FFF);
      in_hires2 = (addr >= 16'h4000) && (addr <= 16'h5FFF);
      in_shr    = bank[0] && (addr >= 16'h2000) && (addr <= 16'h9FFF);
      region_ok = (in_text1  && !shadow[0]) ||
                  (in_text2  && !shadow[5]) ||
                  (in_hires1 && !shadow[1]) ||
                  (in_hires2 && !shadow[2]) ||
                  (in_shr    && !shadow[3]);
      qualify   = fast_clk && we && (bank[7:1] == 7'd0) && region_ok;
   end

   // Pop is evaluated first so a full FIFO can still accept a push when it
   // drains in the same cycle.
   always_comb begin
      full       = (fifo_count == 5'(DEPTH));
      do_pop     = slow_clk && (fifo_count != 5'd0);
      do_push    = qualify && (!full || do_pop);
      count_next = fifo_count + {4'd0, do_push} - {4'd0, do_pop};
   end

   always_ff @(posedge clk_sys) begin
      if (!reset && do_push) begin
         mem[wr_ptr] <= {bank[0], addr, dout};
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= 5'd0;
         stall      <= 1'b0;
         sr_we      <= 1'b0;
         sr_addr    <= 17'd0;
         sr_din     <= 8'd0;
         overflow   <= 1'b0;
      end else begin
         fifo_count <= count_next;
         stall      <= (count_next == 5'(DEPTH));
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         // Read of mem sees the pre-edge value, so a same-slot push while
         // full does not disturb the entry being popped.
         if (do_pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            sr_addr <= mem[rd_ptr][24:8];
            sr_din  <= mem[rd_ptr][7:0];
         end
         sr_we <= do_pop;
         if (qualify && !do_push) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
